// File: rtl/dmem_arb_pkg.sv
// Shared constants and request/response record types for the DMEM arbiter.
package dmem_arb_pkg;
  localparam int PORT_CORE    = 0;
  localparam int PORT_DMA     = 1;
  localparam int NUM_PORTS    = 2;
  localparam int MAX_CONSEC_W = 4;
  localparam int ARB_AW       = 32;
  localparam int ARB_DW       = 32;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic              valid;
    logic [ARB_DW-1:0] rdata;
  } rsp_t;
endpackage

// File: rtl/dmem_arb_fair_cnt.sv
// Saturating count of consecutive core grants made while the DMA port waits.
module dmem_arb_fair_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam logic [MAX_CONSEC_W-1:0] LIMIT = MAX_CONSEC_W'(MAX);

  logic [MAX_CONSEC_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && cnt != LIMIT) cnt <= cnt + 1'b1;
  end

  assign at_limit = (cnt == LIMIT);
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port DMEM: core priority with a
// fairness limit, one registered response outstanding. DMEM_ARB_PERF_EN adds perf counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_CONSEC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [1:0]          req_we_i,
  input  logic [1:0][AW-1:0]  req_addr_i,
  input  logic [1:0][DW-1:0]  req_wdata_i,
  output logic [1:0]          rsp_valid_o,
  input  logic [1:0]          rsp_ready_i,
  output logic [DW-1:0]       rsp_rdata_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic [AW-1:0]       mem_addr_o,
  output logic [DW-1:0]       mem_wdata_o,
  input  logic [DW-1:0]       mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_grant0_o,
  output logic [31:0]         perf_grant1_o,
  output logic [31:0]         perf_stall1_o
`endif
);
  logic [1:0]    rsp_valid_q, held, elig, grant;
  logic [DW-1:0] rsp_rdata_q;
  logic          at_limit, sel, sel_we, any_grant;

  // A response waiting on its consumer blocks every port: only one may be outstanding.
  assign held = rsp_valid_q & ~rsp_ready_i;
  assign elig = req_valid_i & {2{~|held}};

  always_comb begin
    grant = '0;
    if (elig[PORT_DMA] && (!elig[PORT_CORE] || at_limit)) grant[PORT_DMA]  = 1'b1;
    else if (elig[PORT_CORE])                             grant[PORT_CORE] = 1'b1;
  end

  assign any_grant   = |grant;
  assign sel         = grant[PORT_DMA];
  assign sel_we      = req_we_i[sel];
  assign req_ready_o = grant;
  assign mem_read_o  = any_grant & ~sel_we;
  assign mem_write_o = any_grant & sel_we;
  assign mem_addr_o  = req_addr_i[sel];
  assign mem_wdata_o = req_wdata_i[sel];

  dmem_arb_fair_cnt #(.MAX(MAX_CONSEC)) u_fair_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (grant[PORT_CORE] & req_valid_i[PORT_DMA]),
    .clr      (grant[PORT_DMA] | ~req_valid_i[PORT_DMA]),
    .at_limit (at_limit)
  );

  // A same-port grant in the clear cycle keeps valid high with fresh data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant[p])            rsp_valid_q[p] <= 1'b1;
        else if (rsp_ready_i[p]) rsp_valid_q[p] <= 1'b0;
      end
      if (any_grant) rsp_rdata_q <= sel_we ? '0 : mem_rdata_i;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0_o <= '0;
      perf_grant1_o <= '0;
      perf_stall1_o <= '0;
    end else begin
      if (grant[PORT_CORE])                          perf_grant0_o <= perf_grant0_o + 32'd1;
      if (grant[PORT_DMA])                           perf_grant1_o <= perf_grant1_o + 32'd1;
      if (req_valid_i[PORT_DMA] && !grant[PORT_DMA]) perf_stall1_o <= perf_stall1_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// against a transaction-level model with its own memory image.
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, MAXC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid_i, req_ready_o, req_we_i, rsp_valid_o, rsp_ready_i;
  logic [1:0][AW-1:0] req_addr_i;
  logic [1:0][DW-1:0] req_wdata_i;
  logic [DW-1:0] rsp_rdata_o, mem_wdata_o, mem_rdata_i;
  logic [AW-1:0] mem_addr_o;
  logic mem_read_o, mem_write_o;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_grant0_o, perf_grant1_o, perf_stall1_o;
  logic [31:0] pg0, pg1, ps1;
`endif

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_CONSEC(MAXC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
`ifdef DMEM_ARB_PERF_EN
    , .perf_grant0_o(perf_grant0_o), .perf_grant1_o(perf_grant1_o), .perf_stall1_o(perf_stall1_o)
`endif
  );

  function automatic logic [31:0] init_word(int idx);
    return 32'(idx) * 32'h9E3779B9 + 32'h01234567;
  endfunction

  // DMEM environment: combinational read, write at the clock edge.
  logic [31:0] dmem [256];
  bit          dmem_vld [256];
  assign mem_rdata_i = dmem_vld[mem_addr_o[9:2]] ? dmem[mem_addr_o[9:2]]
                                                  : init_word(int'(mem_addr_o[9:2]));
  always @(posedge clk) begin
    if (mem_write_o) begin
      dmem[mem_addr_o[9:2]]     <= mem_wdata_o;
      dmem_vld[mem_addr_o[9:2]] <= 1'b1;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: streak of core wins while DMA waits, one pending response slot,
  // and a private memory image.
  bit          chk_en = 1'b0;
  int          streak;
  logic [1:0]  pend;
  logic [31:0] pend_data;
  logic [31:0] ref_mem [256];
  bit          ref_vld [256];
  logic [1:0]  gnt_log [$];

  always @(negedge clk) begin : model
    logic [1:0] g;
    bit blocked, e0, e1;
    int gp, idx;
    if (!rst_n) begin
      streak = 0;
      pend = '0;
      pend_data = '0;
    end else if (chk_en) begin
      blocked = |(pend & ~rsp_ready_i);
      e0 = req_valid_i[0] && !blocked;
      e1 = req_valid_i[1] && !blocked;
      g = '0;
      if (e1 && (!e0 || streak >= MAXC)) g = 2'b10;
      else if (e0)                       g = 2'b01;
      gnt_log.push_back(req_ready_o);
      chk("req_ready", 32'(req_ready_o), 32'(g));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(pend));
      if (pend != 2'b00) chk("rsp_rdata", rsp_rdata_o, pend_data);
      if (g != 2'b00) begin
        gp = g[1] ? 1 : 0;
        chk("mem_read", 32'(mem_read_o), 32'(!req_we_i[gp]));
        chk("mem_write", 32'(mem_write_o), 32'(req_we_i[gp]));
        chk("mem_addr", mem_addr_o, req_addr_i[gp]);
        if (req_we_i[gp]) chk("mem_wdata", mem_wdata_o, req_wdata_i[gp]);
      end else begin
        chk("mem_idle", 32'({mem_read_o, mem_write_o}), 32'h0);
      end
      pend = pend & ~rsp_ready_i;
      if (g != 2'b00) begin
        idx = int'(req_addr_i[gp][9:2]);
        pend[gp] = 1'b1;
        if (req_we_i[gp]) begin
          pend_data = '0;
          ref_mem[idx] = req_wdata_i[gp];
          ref_vld[idx] = 1'b1;
        end else begin
          pend_data = ref_vld[idx] ? ref_mem[idx] : init_word(idx);
        end
      end
      if (g[0] && req_valid_i[1]) streak = (streak < MAXC) ? streak + 1 : MAXC;
      else if (g[1] || !req_valid_i[1]) streak = 0;
    end
  end

  task automatic set_req(int p, logic v, logic we, logic [31:0] addr, logic [31:0] wd);
    req_valid_i[p] = v;
    req_we_i[p]    = we;
    req_addr_i[p]  = addr;
    req_wdata_i[p] = wd;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] acc;
    logic [31:0] r;
    int n_dma;
    req_valid_i = '0; req_we_i = '0; req_addr_i = '0; req_wdata_i = '0;
    rsp_ready_i = 2'b11;
    #1;
    chk("reset rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("reset rsp_rdata", rsp_rdata_o, 32'h0);
`ifdef DMEM_ARB_PERF_EN
    chk("reset perf_grant0", perf_grant0_o, 32'h0);
    chk("reset perf_stall1", perf_stall1_o, 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("idle mem_read", 32'(mem_read_o), 32'h0);
    next_cyc();

    // Core write then read of 0x10
    set_req(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("s1 wr ready", 32'(req_ready_o), 32'h1);
    chk("s1 mem_write", 32'(mem_write_o), 32'h1);
    next_cyc();
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("s1 rd ready", 32'(req_ready_o), 32'h1);
    chk("s1 wr ack data", rsp_rdata_o, 32'h0);
    next_cyc();
    req_valid_i = '0;
    @(negedge clk);
    chk("s1 rd valid", 32'(rsp_valid_o), 32'h1);
    chk("s1 rd data", rsp_rdata_o, 32'hDEADBEEF);
    next_cyc();

    // Back-to-back core reads of 0x0 and 0x4
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("s4 ready a", 32'(req_ready_o), 32'h1);
    next_cyc();
    set_req(0, 1'b1, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    chk("s4 ready b", 32'(req_ready_o), 32'h1);
    chk("s4 data a", rsp_rdata_o, 32'h01234567);
    next_cyc();
    req_valid_i = '0;
    @(negedge clk);
    chk("s4 data b", rsp_rdata_o, 32'h9F5ABF20);
    next_cyc();

    // DMA read held by rsp_ready low for 3 cycles
    set_req(1, 1'b1, 1'b0, 32'h10, 32'h0);
    rsp_ready_i = 2'b01;
    @(negedge clk);
    chk("s3 dma grant", 32'(req_ready_o), 32'h2);
    next_cyc();
    set_req(0, 1'b1, 1'b0, 32'h4, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h8, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("s3 stalled ready", 32'(req_ready_o), 32'h0);
      chk("s3 held valid", 32'(rsp_valid_o), 32'h2);
      chk("s3 held data", rsp_rdata_o, 32'hDEADBEEF);
      next_cyc();
    end
    rsp_ready_i = 2'b11;
    @(negedge clk);
    chk("s3 resume grant", 32'(req_ready_o), 32'h1);
    next_cyc();
    req_valid_i[0] = 1'b0;
    @(negedge clk);
    chk("s3 dma served", 32'(req_ready_o), 32'h2);
    next_cyc();
    req_valid_i = '0;
    next_cyc();

    // Both ports saturated for 50 cycles
    set_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h24, 32'h0);
`ifdef DMEM_ARB_PERF_EN
    pg0 = perf_grant0_o; pg1 = perf_grant1_o; ps1 = perf_stall1_o;
`endif
    gnt_log.delete();
    repeat (50) next_cyc();
    req_valid_i = '0;
    n_dma = 0;
    for (int i = 0; i < gnt_log.size(); i++) if (gnt_log[i] == 2'b10) n_dma++;
    chk("s2 log size", 32'(gnt_log.size()), 32'd50);
    chk("s2 dma grants", 32'(n_dma), 32'd10);
    for (int i = 0; i < 10 && i < gnt_log.size(); i++)
      chk("s2 pattern", 32'(gnt_log[i]), (i % 5 == 4) ? 32'h2 : 32'h1);
`ifdef DMEM_ARB_PERF_EN
    chk("perf_grant0", perf_grant0_o - pg0, 32'd40);
    chk("perf_grant1", perf_grant1_o - pg1, 32'd10);
    chk("perf_stall1", perf_stall1_o - ps1, 32'd40);
`endif
    next_cyc();

    // Reset with a response pending
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    rsp_ready_i = 2'b00;
    next_cyc();
    req_valid_i = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("s5 async clear", 32'(rsp_valid_o), 32'h0);
`ifdef DMEM_ARB_PERF_EN
    chk("s5 perf clear", perf_grant0_o, 32'h0);
`endif
    next_cyc();
    rst_n = 1'b1;
    rsp_ready_i = 2'b11;
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("s5 post ready", 32'(req_ready_o), 32'h1);
    next_cyc();
    req_valid_i = '0;
    @(negedge clk);
    chk("s5 post data", rsp_rdata_o, 32'hDEADBEEF);
    next_cyc();

    // Random traffic honouring the hold-until-ready protocol
    acc = '0;
    repeat (3000) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_valid_i[p] || acc[p]) begin
          r = $urandom;
          req_valid_i[p] = ($urandom_range(0, 99) < 60);
          req_we_i[p]    = 1'($urandom_range(0, 1));
          req_addr_i[p]  = {r[31:10], 4'b0000, 4'($urandom_range(0, 15)), 2'b00};
          req_wdata_i[p] = $urandom;
        end
        rsp_ready_i[p] = ($urandom_range(0, 99) < 70);
      end
      @(negedge clk);
      acc = req_ready_o;
      next_cyc();
    end
    req_valid_i = '0;
    rsp_ready_i = 2'b11;
    repeat (2) next_cyc();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
